// File: rtl/t5_wbarb_pkg.sv
// Shared constants for the t5 instruction/data Wishbone arbiter.
package t5_wbarb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    localparam int CNT_W = 16;

endpackage

// File: rtl/t5_wbarb_tout.sv
// Watchdog for the arbiter's BUSY phase: flags the TOUT-th consecutive BUSY cycle.
module t5_wbarb_tout
    import t5_wbarb_pkg::*;
#(
    parameter int TOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_busy,
    output logic o_hit
);

    localparam logic [CNT_W-1:0] LIM = CNT_W'(TOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Held at zero outside BUSY, so every BUSY entry starts a fresh count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (!i_busy)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_hit = i_busy && (r_cnt == LIM);

endmodule

// File: rtl/t5_wbarb.sv
// Two-master (iwb/dwb) to one-slave Wishbone arbiter for the t5 core.
// Optional watchdog on the slave phase: define T5_WBARB_TOUT_EN.
module t5_wbarb
    import t5_wbarb_pkg::*;
#(
    parameter int DPRI = 0,
    parameter int TOUT = 255
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [29:0] iwb_adr,
    input  logic        iwb_stb,
    input  logic [3:0]  iwb_sel,
    output logic [31:0] iwb_dat,
    output logic        iwb_ack,
    input  logic [29:0] dwb_adr,
    input  logic [31:0] dwb_dto,
    input  logic [3:0]  dwb_sel,
    input  logic        dwb_wre,
    input  logic        dwb_stb,
    output logic [31:0] dwb_dti,
    output logic        dwb_ack,
    output logic [29:0] mwb_adr,
    output logic [31:0] mwb_dto,
    output logic [3:0]  mwb_sel,
    output logic        mwb_wre,
    output logic        mwb_stb,
    output logic        mwb_cyc,
    input  logic [31:0] mwb_dti,
    input  logic        mwb_ack,
    output logic        mwb_err
);

    if ((TOUT < 1) || (TOUT > 65535)) begin : g_bad_tout
        $error("t5_wbarb: TOUT must be in 1..65535");
    end

    logic [1:0]  r_state;
    logic        r_gnt;
    logic        r_last;
    logic [29:0] r_adr;
    logic [31:0] r_dto;
    logic [3:0]  r_sel;
    logic        r_wre;
    logic        r_stb;
    logic [31:0] r_idat;
    logic        r_iack;
    logic [31:0] r_ddat;
    logic        r_dack;
    logic        w_pick_d;
    logic        w_tout;

    // dwb wins if alone, under fixed priority, or when iwb was served last.
    assign w_pick_d = dwb_stb && (!iwb_stb || (DPRI != 0) || (r_last == GNT_I));

`ifdef T5_WBARB_TOUT_EN
    logic r_err;

    t5_wbarb_tout #(
        .TOUT (TOUT)
    ) u_tout (
        .i_clk  (sys_clk),
        .i_rst  (sys_rst),
        .i_busy (r_state == BUSY),
        .o_hit  (w_tout)
    );

    assign mwb_err = r_err;
`else
    assign w_tout  = 1'b0;
    assign mwb_err = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= IDLE;
            r_gnt   <= GNT_I;
            r_last  <= GNT_D;
            r_adr   <= '0;
            r_dto   <= '0;
            r_sel   <= '0;
            r_wre   <= 1'b0;
            r_stb   <= 1'b0;
            r_idat  <= '0;
            r_iack  <= 1'b0;
            r_ddat  <= '0;
            r_dack  <= 1'b0;
`ifdef T5_WBARB_TOUT_EN
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (iwb_stb || dwb_stb) begin
                        r_gnt   <= w_pick_d ? GNT_D : GNT_I;
                        r_adr   <= w_pick_d ? dwb_adr : iwb_adr;
                        r_sel   <= w_pick_d ? dwb_sel : iwb_sel;
                        r_dto   <= w_pick_d ? dwb_dto : 32'h0;
                        r_wre   <= w_pick_d && dwb_wre;
                        r_stb   <= 1'b1;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    // A real ack beats a watchdog expiry in the same cycle.
                    if (mwb_ack || w_tout) begin
                        r_stb   <= 1'b0;
                        r_last  <= r_gnt;
                        r_state <= DONE;
                        if (r_gnt == GNT_D) begin
                            r_ddat <= mwb_ack ? mwb_dti : 32'h0;
                            r_dack <= 1'b1;
                        end else begin
                            r_idat <= mwb_ack ? mwb_dti : 32'h0;
                            r_iack <= 1'b1;
                        end
`ifdef T5_WBARB_TOUT_EN
                        r_err  <= !mwb_ack;
`endif
                    end
                end
                DONE: begin
                    r_iack  <= 1'b0;
                    r_dack  <= 1'b0;
`ifdef T5_WBARB_TOUT_EN
                    r_err   <= 1'b0;
`endif
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mwb_adr = r_adr;
    assign mwb_dto = r_dto;
    assign mwb_sel = r_sel;
    assign mwb_wre = r_wre;
    assign mwb_stb = r_stb;
    assign mwb_cyc = r_stb;
    assign iwb_dat = r_idat;
    assign iwb_ack = r_iack;
    assign dwb_dti = r_ddat;
    assign dwb_ack = r_dack;

endmodule

// File: tb/tb_t5_wbarb.sv
// Self-checking bench for t5_wbarb: a round-robin and a fixed-priority instance share stimulus.
module tb_t5_wbarb;

    logic        clk = 1'b0;
    logic        rst;
    logic [29:0] iwb_adr;
    logic        iwb_stb;
    logic [3:0]  iwb_sel;
    logic [29:0] dwb_adr;
    logic [31:0] dwb_dto;
    logic [3:0]  dwb_sel;
    logic        dwb_wre;
    logic        dwb_stb;
    logic [31:0] sdata;
    int          wait_n;

    logic [31:0] iwb_dat0, dwb_dti0, mwb_dto0, iwb_dat1, dwb_dti1, mwb_dto1;
    logic [29:0] mwb_adr0, mwb_adr1;
    logic [3:0]  mwb_sel0, mwb_sel1;
    logic        iwb_ack0, dwb_ack0, mwb_wre0, mwb_stb0, mwb_cyc0, mwb_err0, ack0;
    logic        iwb_ack1, dwb_ack1, mwb_wre1, mwb_stb1, mwb_cyc1, mwb_err1, ack1;

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    t5_wbarb #(.DPRI(0), .TOUT(8)) dut0 (
        .sys_clk(clk), .sys_rst(rst),
        .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_sel(iwb_sel),
        .iwb_dat(iwb_dat0), .iwb_ack(iwb_ack0),
        .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel),
        .dwb_wre(dwb_wre), .dwb_stb(dwb_stb),
        .dwb_dti(dwb_dti0), .dwb_ack(dwb_ack0),
        .mwb_adr(mwb_adr0), .mwb_dto(mwb_dto0), .mwb_sel(mwb_sel0),
        .mwb_wre(mwb_wre0), .mwb_stb(mwb_stb0), .mwb_cyc(mwb_cyc0),
        .mwb_dti(sdata), .mwb_ack(ack0), .mwb_err(mwb_err0)
    );

    t5_wbarb #(.DPRI(1), .TOUT(8)) dut1 (
        .sys_clk(clk), .sys_rst(rst),
        .iwb_adr(iwb_adr), .iwb_stb(iwb_stb), .iwb_sel(iwb_sel),
        .iwb_dat(iwb_dat1), .iwb_ack(iwb_ack1),
        .dwb_adr(dwb_adr), .dwb_dto(dwb_dto), .dwb_sel(dwb_sel),
        .dwb_wre(dwb_wre), .dwb_stb(dwb_stb),
        .dwb_dti(dwb_dti1), .dwb_ack(dwb_ack1),
        .mwb_adr(mwb_adr1), .mwb_dto(mwb_dto1), .mwb_sel(mwb_sel1),
        .mwb_wre(mwb_wre1), .mwb_stb(mwb_stb1), .mwb_cyc(mwb_cyc1),
        .mwb_dti(sdata), .mwb_ack(ack1), .mwb_err(mwb_err1)
    );

    // Slave: acks after wait_n stalled cycles of strobe.
    int cnt0, cnt1;
    assign ack0 = mwb_stb0 && (cnt0 == wait_n);
    assign ack1 = mwb_stb1 && (cnt1 == wait_n);
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= 0;
            cnt1 <= 0;
        end else begin
            cnt0 <= (!mwb_stb0 || ack0) ? 0 : cnt0 + 1;
            cnt1 <= (!mwb_stb1 || ack1) ? 0 : cnt1 + 1;
        end
    end

    task automatic chk(input string nm, input logic [135:0] a, input logic [135:0] e);
        total++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s: got %h want %h", nm, a, e);
    endtask

    // Transaction-level model of the round-robin instance.
    logic        m_xfer, m_show, m_own, m_last;
    int          m_wait;
    logic [29:0] e_adr;
    logic [31:0] e_dto, e_idat, e_ddat;
    logic [3:0]  e_sel;
    logic        e_wre, e_stb, e_iack, e_dack, e_err;
    logic        m_ack, m_to, m_pick_d;

    assign m_ack    = m_xfer && (m_wait == wait_n);
`ifdef T5_WBARB_TOUT_EN
    assign m_to     = m_xfer && !m_ack && (m_wait == 7);
`else
    assign m_to     = 1'b0;
`endif
    assign m_pick_d = dwb_stb && (!iwb_stb || !m_last);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_xfer <= 0; m_show <= 0; m_own <= 0; m_last <= 1; m_wait <= 0;
            e_adr <= 0; e_dto <= 0; e_sel <= 0; e_wre <= 0; e_stb <= 0;
            e_idat <= 0; e_ddat <= 0; e_iack <= 0; e_dack <= 0; e_err <= 0;
        end else if (m_show) begin
            m_show <= 0; e_iack <= 0; e_dack <= 0; e_err <= 0;
        end else if (m_xfer) begin
            if (m_ack || m_to) begin
                e_stb <= 0; m_xfer <= 0; m_show <= 1; m_last <= m_own;
                e_err <= m_to;
                if (m_own) begin e_dack <= 1; e_ddat <= m_ack ? sdata : 32'h0; end
                else       begin e_iack <= 1; e_idat <= m_ack ? sdata : 32'h0; end
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (iwb_stb || dwb_stb) begin
            m_xfer <= 1; m_wait <= 0; m_own <= m_pick_d; e_stb <= 1;
            e_adr  <= m_pick_d ? dwb_adr : iwb_adr;
            e_sel  <= m_pick_d ? dwb_sel : iwb_sel;
            e_dto  <= m_pick_d ? dwb_dto : 32'h0;
            e_wre  <= m_pick_d && dwb_wre;
        end
    end

    always @(negedge clk)
        chk("cycle",
            {mwb_adr0, mwb_dto0, mwb_sel0, mwb_wre0, mwb_stb0, mwb_cyc0, mwb_err0,
             iwb_dat0, iwb_ack0, dwb_dti0, dwb_ack0},
            {e_adr, e_dto, e_sel, e_wre, e_stb, e_stb, e_err,
             e_idat, e_iack, e_ddat, e_dack});

    // Grant recorder: 1 = dwb won (dwb uses address 30'h200 during contention).
    logic       rec_en;
    logic       p0, p1;
    logic [7:0] g0, g1;
    int         n0, n1;
    always @(negedge clk) begin
        p0 <= mwb_stb0;
        p1 <= mwb_stb1;
        if (!rec_en) begin
            g0 <= 0; g1 <= 0; n0 <= 0; n1 <= 0;
        end else begin
            if (mwb_stb0 && !p0) begin g0 <= {g0[6:0], mwb_adr0 == 30'h200}; n0 <= n0 + 1; end
            if (mwb_stb1 && !p1) begin g1 <= {g1[6:0], mwb_adr1 == 30'h200}; n1 <= n1 + 1; end
        end
    end

    task automatic wait_ack(input bit d, output int n, output bit ok);
        n  = 0;
        ok = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clk);
            n++;
            if (d ? dwb_ack0 : iwb_ack0) ok = 1;
        end
    endtask

    int n;
    bit ok;

    initial begin
        rst = 1; rec_en = 0; wait_n = 0; sdata = 0;
        iwb_adr = 0; iwb_stb = 0; iwb_sel = 0;
        dwb_adr = 0; dwb_dto = 0; dwb_sel = 0; dwb_wre = 0; dwb_stb = 0;
        repeat (2) @(negedge clk);
        chk("reset", {mwb_stb0, mwb_cyc0, iwb_ack0, dwb_ack0, mwb_adr0}, 0);
        rst = 0;

        // single instruction read, slave stalls two cycles
        wait_n = 2; sdata = 32'hDEADBEEF;
        iwb_adr = 30'h10; iwb_sel = 4'hF; iwb_stb = 1;
        wait_ack(0, n, ok);
        chk("iread_ack", ok, 1);
        chk("iread_dat", iwb_dat0, 32'hDEADBEEF);
        chk("iread_bus", {mwb_adr0, mwb_wre0, dwb_ack0}, {30'h10, 1'b0, 1'b0});
        iwb_stb = 0;
        repeat (2) @(negedge clk);

        // single data write, zero-wait slave
        wait_n = 0; sdata = 32'h0;
        dwb_adr = 30'h20; dwb_wre = 1; dwb_sel = 4'b0011; dwb_dto = 32'h1234; dwb_stb = 1;
        wait_ack(1, n, ok);
        chk("dwrite_lat", n, 2);
        chk("dwrite_bus", {mwb_adr0, mwb_dto0, mwb_sel0, mwb_wre0},
            {30'h20, 32'h1234, 4'b0011, 1'b1});
        dwb_stb = 0; dwb_wre = 0;
        @(negedge clk);
        chk("dwrite_ack1cyc", {dwb_ack0, iwb_ack0}, 0);

        // contention from reset: rr alternates from I, priority always D
        rst = 1;
        @(negedge clk);
        rst = 0; rec_en = 1;
        iwb_adr = 30'h100; dwb_adr = 30'h200; sdata = 32'h5A5A0000;
        iwb_stb = 1; dwb_stb = 1;
        repeat (12) @(negedge clk);
        dwb_stb = 0;
        repeat (3) @(negedge clk);
        iwb_stb = 0;
        @(negedge clk);
        chk("rr_grants",  {n0, g0[4:0]}, {32'd5, 5'b01010});
        chk("pri_grants", {n1, g1[4:0]}, {32'd5, 5'b11110});
        rec_en = 0;
        repeat (2) @(negedge clk);

        // reset while the slave is stalled
        wait_n = 5; iwb_adr = 30'h44; iwb_stb = 1;
        repeat (2) @(negedge clk);
        chk("busy_before_rst", mwb_stb0, 1);
        #1 rst = 1;
        #1 chk("rst_async", {mwb_stb0, mwb_cyc0, iwb_ack0}, 0);
        @(negedge clk);
        chk("rst_noack", {iwb_ack0, dwb_ack0}, 0);
        rst = 0; wait_n = 0; sdata = 32'hCAFE0001;
        wait_ack(0, n, ok);
        chk("post_rst_lat", n, 2);
        chk("post_rst_dat", iwb_dat0, 32'hCAFE0001);
        iwb_stb = 0;
        repeat (2) @(negedge clk);

`ifdef T5_WBARB_TOUT_EN
        // slave never acks: watchdog ends the transfer after 8 BUSY cycles
        wait_n = 100; sdata = 32'h12345678; iwb_adr = 30'h50; iwb_stb = 1;
        wait_ack(0, n, ok);
        chk("tout_lat", n, 9);
        chk("tout_resp", {iwb_dat0, mwb_err0, mwb_stb0}, {32'h0, 1'b1, 1'b0});
        iwb_stb = 0;
        @(negedge clk);
        chk("tout_err1cyc", mwb_err0, 0);
        wait_n = 0; sdata = 32'h0BADF00D; dwb_adr = 30'h60; dwb_stb = 1;
        wait_ack(1, n, ok);
        chk("tout_recover", {n, dwb_dti0, mwb_err0}, {32'd2, 32'h0BADF00D, 1'b0});
        dwb_stb = 0;
        repeat (2) @(negedge clk);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/t5_wbarb.md
Name: t5_wbarb

Overview:
Two-master to one-slave Wishbone arbiter for the t5 core. It shares a single external memory port between the instruction bus (iwb_*) and the data bus (dwb_*). Each transfer is granted to one requester, forwarded with registered signals, and the returned ack and data are registered back to the winning requester only. It sits between the t5_rv32i core ports and the system memory.

Parameters:
DPRI, 0, arbitration mode: 0 = round-robin between requesters, 1 = fixed priority to the data bus.
TOUT, 255, watchdog limit in cycles while BUSY; used only with T5_WBARB_TOUT_EN; legal range 1..65535.

Ports:
sys_clk  in  1  clock; all state updates on its rising edge.
sys_rst  in  1  asynchronous reset, active-high.
iwb_adr  in  30  instruction word address [31:2].
iwb_stb  in  1  instruction request.
iwb_sel  in  4  instruction byte lanes.
iwb_dat  out  32  instruction read data; valid while iwb_ack is high.
iwb_ack  out  1  instruction transfer done; one-cycle pulse.
dwb_adr  in  30  data word address [31:2].
dwb_dto  in  32  store data.
dwb_sel  in  4  data byte lanes.
dwb_wre  in  1  data write enable.
dwb_stb  in  1  data request.
dwb_dti  out  32  load data; valid while dwb_ack is high.
dwb_ack  out  1  data transfer done; one-cycle pulse.
mwb_adr  out  30  slave address.
mwb_dto  out  32  slave write data.
mwb_sel  out  4  slave byte lanes.
mwb_wre  out  1  slave write enable.
mwb_stb  out  1  slave strobe.
mwb_cyc  out  1  slave cycle; identical to mwb_stb.
mwb_dti  in  32  slave read data.
mwb_ack  in  1  slave ack.
mwb_err  out  1  timeout pulse; tied 0 without T5_WBARB_TOUT_EN.

Behaviour:
- Reset values: all outputs 0; state = IDLE; grant = none; last-served = data, so the first contested request goes to iwb.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE: sample iwb_stb and dwb_stb.
  - Neither asserted: stay in IDLE.
  - Exactly one asserted: grant it.
  - Both asserted, DPRI=0: grant the requester not served last.
  - Both asserted, DPRI=1: grant dwb.
  - On a grant: register the winner's adr/sel/dto/wre into the mwb_* outputs (wre is forced 0 for iwb), set mwb_stb = mwb_cyc = 1, go to BUSY.
- BUSY: hold all mwb_* outputs stable. On mwb_ack:
  - Clear mwb_stb/mwb_cyc.
  - Register mwb_dti into the granted side's dat/dti output.
  - Pulse the granted side's ack for one cycle.
  - Update last-served; go to DONE.
- DONE: exactly one cycle with the ack high. Requester inputs are ignored, so a stb still high in this cycle is not re-sampled. Then go to IDLE, with the ack low again.
- Latency:
  - Request seen at edge N -> mwb_stb high after edge N.
  - mwb_ack at edge M -> requester ack high during the cycle after edge M.
  - Minimum 3 cycles per transfer; back-to-back throughput is one transfer per 3 cycles (zero-wait slave).
- Non-granted requester: ack held 0; its dat/dti output keeps its last value.
- Requester rule: stb must stay high until ack. Deasserting stb before ack has no effect on the transfer already in flight.
- mwb_ack while not in BUSY is ignored.
- sys_rst mid-transfer: return immediately to the reset values, with mwb_stb dropped asynchronously. The interrupted transfer gets no ack.

Optional Feature:
- Macro: T5_WBARB_TOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to BUSY and increments each BUSY cycle.
  - If the count reaches TOUT with no mwb_ack: drop mwb_stb, pulse mwb_err for one cycle, return a one-cycle ack with data 32'h0 to the granted side, update last-served, go to DONE.
  - If mwb_ack arrives in the same cycle the count reaches TOUT, the ack wins and no error is raised.
- Undefined: no counter is built; BUSY waits indefinitely for mwb_ack; mwb_err is constant 0.

Decomposition:
- A shared package t5_wbarb_pkg holds:
  - the state encoding constants (IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2);
  - grant encoding constants (GNT_I, GNT_D).
- One sub-module, t5_wbarb_tout, holds the watchdog counter. It is instantiated only under the macro.

Test Plan:
- Single iwb read: iwb_stb with iwb_adr = 30'h10; slave acks 2 cycles after mwb_stb with mwb_dti = 32'hDEADBEEF -> mwb_adr = 30'h10, mwb_wre = 0, one-cycle iwb_ack with iwb_dat = 32'hDEADBEEF; dwb_ack stays 0.
- Single dwb write: dwb_wre = 1, dwb_sel = 4'b0011, dwb_dto = 32'h1234 -> mwb_* mirror these values; one-cycle dwb_ack; 3-cycle total with a zero-wait slave.
- Contention, DPRI=0: both stb held high for 4 transfers -> grants alternate I, D, I, D starting with I after reset.
- Contention, DPRI=1: both stb held high -> every grant goes to D while dwb_stb stays high; I is granted only after dwb_stb drops.
- Reset mid-BUSY: assert sys_rst while mwb_stb is high -> mwb_stb drops asynchronously, no ack is issued, and the next request after reset starts in IDLE.
- Timeout (macro defined, TOUT = 8): slave never acks -> after 8 BUSY cycles mwb_err pulses once, the granted ack pulses with data 0, and the next request proceeds normally.
